sseg_scan_ctrl: RTL and testbench

- Memory-mapped controller that owns the 8-digit seven-segment display on the RISC-V SoC bus.
- Schedules digit multiplexing with a programmable slot length.
- Inserts anti-ghosting blanking between digits and applies per-digit enable plus PWM brightness.
- Shadows CPU-written value and decimal-point registers at frame boundaries to prevent tearing.

---
 rtl/sseg_scan_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_sseg_scan_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_ctrl.sv
// Bus-mapped 8-digit seven-segment scan controller: blanking, per-digit mask, PWM brightness,
// frame-synchronous shadowing. Define SSEG_LZS_EN to enable leading-zero suppression.
module sseg_scan_ctrl #(
  parameter int unsigned PRESCALE     = 1024,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_sel,
  input  logic        bus_we,
  input  logic [1:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic [7:0]  SSEG_CA,
  output logic [7:0]  SSEG_AN
);
  localparam int unsigned   CW         = $clog2(PRESCALE);
  localparam int unsigned   SPAN       = PRESCALE - BLANK_CYCLES;
  localparam logic [CW-1:0] CNT_LAST   = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_ON, S_OFF} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    digit_q, digit_d;
  logic [7:0]    frame_q, frame_d;
  logic [31:0]   value_q, value_d;
  logic [7:0]    dp_q, dp_d;
  logic          en_q, en_d;
  logic [7:0]    digmask_q, digmask_d;
  logic [3:0]    bright_q, bright_d;
  logic [31:0]   val_sh_q, val_sh_d;
  logic [7:0]    dp_sh_q, dp_sh_d;
  logic [3:0]    bright_slot_q, bright_slot_d;
  logic [7:0]    mask_slot_q, mask_slot_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [7:0]    an_q, an_d;
  logic [7:0]    ca_q, ca_d;
  logic          slot_start;
  logic          load_sh;
  logic [31:0]   on_len;
  logic [CW-1:0] on_last;
  logic          digit_vis;
  logic [3:0]    nibble;

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

`ifdef SSEG_LZS_EN
  logic [2:0] lzs_h_q, lzs_h_d;

  function automatic logic [2:0] top_nonzero(input logic [31:0] v);
    logic [2:0] h;
    h = '0;
    for (int unsigned i = 0; i < 8; i++)
      if (v[4*i +: 4] != 4'h0) h = 3'(i);
    return h;
  endfunction

  always_comb begin
    lzs_h_d = lzs_h_q;
    if (load_sh) lzs_h_d = top_nonzero(value_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lzs_h_q <= '0;
    else     lzs_h_q <= lzs_h_d;
  end

  // Digits above the highest nonzero nibble stay dark unless their DP is lit.
  assign digit_vis = mask_slot_q[digit_q] && ((digit_q <= lzs_h_q) || dp_sh_q[digit_q]);
`else
  assign digit_vis = mask_slot_q[digit_q];
`endif

  assign nibble  = val_sh_q[{digit_q, 2'b00} +: 4];
  assign on_len  = ((32'(bright_slot_q) + 32'd1) * SPAN) >> 4;
  assign on_last = CW'(32'(BLANK_CYCLES) + on_len - 32'd1);

  always_comb begin
    value_d   = value_q;
    dp_d      = dp_q;
    en_d      = en_q;
    digmask_d = digmask_q;
    bright_d  = bright_q;
    rdata_d   = rdata_q;
    if (bus_sel && bus_we) begin
      case (bus_addr)
        2'd0: value_d = bus_wdata;
        2'd1: begin
          en_d      = bus_wdata[0];
          digmask_d = bus_wdata[15:8];
          bright_d  = bus_wdata[19:16];
        end
        2'd2:    dp_d = bus_wdata[7:0];
        default: ;
      endcase
    end
    if (bus_sel && !bus_we) begin
      case (bus_addr)
        2'd0:    rdata_d = value_q;
        2'd1:    rdata_d = {12'h000, bright_q, digmask_q, 7'h00, en_q};
        2'd2:    rdata_d = {24'h000000, dp_q};
        default: rdata_d = {16'h0000, frame_q, 5'h00, digit_q};
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    digit_d       = digit_q;
    frame_d       = frame_q;
    val_sh_d      = val_sh_q;
    dp_sh_d       = dp_sh_q;
    bright_slot_d = bright_slot_q;
    mask_slot_d   = mask_slot_q;
    slot_start    = 1'b0;
    load_sh       = 1'b0;
    if (!en_q) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d    = S_BLANK;
          cnt_d      = '0;
          digit_d    = 3'd7;
          slot_start = 1'b1;
          load_sh    = 1'b1;
        end
        S_BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BLANK_LAST) state_d = S_ON;
        end
        S_ON, S_OFF: begin
          // Slot end wins over ON->OFF so full brightness runs ON to the slot edge.
          if (cnt_q == CNT_LAST) begin
            state_d    = S_BLANK;
            cnt_d      = '0;
            digit_d    = digit_q - 3'd1;
            slot_start = 1'b1;
            if (digit_q == 3'd0) begin
              frame_d = frame_q + 8'd1;
              load_sh = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (state_q == S_ON && cnt_q == on_last) state_d = S_OFF;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (slot_start) begin
      bright_slot_d = bright_q;
      mask_slot_d   = digmask_q;
    end
    if (load_sh) begin
      val_sh_d = value_q;
      dp_sh_d  = dp_q;
    end
  end

  always_comb begin
    an_d = '1;
    ca_d = '1;
    if (en_q && state_q == S_ON) begin
      ca_d = {~dp_sh_q[digit_q], hex_seg(nibble)};
      if (digit_vis) an_d = ~(8'd1 << digit_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      digit_q       <= 3'd7;
      frame_q       <= '0;
      value_q       <= '0;
      dp_q          <= '0;
      en_q          <= 1'b0;
      digmask_q     <= '1;
      bright_q      <= '1;
      val_sh_q      <= '0;
      dp_sh_q       <= '0;
      bright_slot_q <= '1;
      mask_slot_q   <= '1;
      rdata_q       <= '0;
      an_q          <= '1;
      ca_q          <= '1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      digit_q       <= digit_d;
      frame_q       <= frame_d;
      value_q       <= value_d;
      dp_q          <= dp_d;
      en_q          <= en_d;
      digmask_q     <= digmask_d;
      bright_q      <= bright_d;
      val_sh_q      <= val_sh_d;
      dp_sh_q       <= dp_sh_d;
      bright_slot_q <= bright_slot_d;
      mask_slot_q   <= mask_slot_d;
      rdata_q       <= rdata_d;
      an_q          <= an_d;
      ca_q          <= ca_d;
    end
  end

  assign bus_rdata = rdata_q;
  assign SSEG_AN   = an_q;
  assign SSEG_CA   = ca_q;
endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Self-checking bench for sseg_scan_ctrl: slot-position model compared every cycle plus
// directed literal checks of scan order, timing, shadowing, masking, enable and reset.
module tb_sseg_scan_ctrl;
  localparam int P = 64;
  localparam int B = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_sel = 1'b0;
  logic        bus_we = 1'b0;
  logic [1:0]  bus_addr = 2'd0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic [7:0]  SSEG_CA;
  logic [7:0]  SSEG_AN;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sseg_scan_ctrl #(.PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst(rst), .bus_sel(bus_sel), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .SSEG_CA(SSEG_CA), .SSEG_AN(SSEG_AN)
  );

  logic [7:0] SEG [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
    end
  endtask

  // Model: scan position counted in cycles since enable; slot, digit and frame follow by division.
  logic [31:0] m_value, sh_val;
  logic [7:0]  m_dp, m_mask, sh_dp, s_mask, exp_an, exp_ca, seg_t;
  logic [3:0]  m_bright, s_bright;
  logic        m_en, m_run, rd_chk;
  logic [31:0] exp_rd;
  int          m_pos, m_digit, m_frame, lz_h, off_i, on_n;
  logic        vis;

  function automatic int top_nz(input logic [31:0] v);
    int h = 0;
    for (int i = 0; i < 8; i++) if (((v >> (4*i)) & 32'hF) != 0) h = i;
    return h;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_value = '0; m_dp = '0; m_en = 1'b0; m_mask = 8'hFF; m_bright = 4'hF;
      m_run = 1'b0; m_pos = 0; m_digit = 7; m_frame = 0; sh_val = '0; sh_dp = '0;
      s_mask = 8'hFF; s_bright = 4'hF; lz_h = 0;
      exp_an = 8'hFF; exp_ca = 8'hFF; exp_rd = '0; rd_chk = 1'b0;
    end else begin
      exp_an = 8'hFF;
      exp_ca = 8'hFF;
      if (m_en && m_run) begin
        off_i = m_pos % P;
        on_n  = ((int'(s_bright) + 1) * (P - B)) / 16;
        if (off_i >= B && off_i < B + on_n) begin
          seg_t  = SEG[sh_val[4*m_digit +: 4]];
          exp_ca = {~sh_dp[m_digit], seg_t[6:0]};
          vis    = s_mask[m_digit];
`ifdef SSEG_LZS_EN
          vis    = vis && (m_digit <= lz_h || sh_dp[m_digit]);
`endif
          if (vis) exp_an = ~(8'd1 << m_digit);
        end
      end
      rd_chk = bus_sel && !bus_we;
      if (rd_chk) begin
        case (bus_addr)
          2'd0:    exp_rd = m_value;
          2'd1:    exp_rd = {12'h000, m_bright, m_mask, 7'h00, m_en};
          2'd2:    exp_rd = {24'h0, m_dp};
          default: exp_rd = {16'h0, 8'(m_frame), 5'h00, 3'(m_digit)};
        endcase
      end
      if (!m_en) begin
        m_run = 1'b0;
      end else if (!m_run) begin
        m_run = 1'b1; m_pos = 0; m_digit = 7;
        s_bright = m_bright; s_mask = m_mask;
        sh_val = m_value; sh_dp = m_dp; lz_h = top_nz(m_value);
      end else begin
        m_pos++;
        if (m_pos % P == 0) begin
          s_bright = m_bright; s_mask = m_mask;
          m_digit = 7 - ((m_pos / P) % 8);
          if (m_pos % (8 * P) == 0) begin
            m_frame = (m_frame + 1) % 256;
            sh_val = m_value; sh_dp = m_dp; lz_h = top_nz(m_value);
          end
        end
      end
      if (bus_sel && bus_we) begin
        case (bus_addr)
          2'd0: m_value = bus_wdata;
          2'd1: begin m_en = bus_wdata[0]; m_mask = bus_wdata[15:8]; m_bright = bus_wdata[19:16]; end
          2'd2: m_dp = bus_wdata[7:0];
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    chk("model_an", {24'h0, SSEG_AN}, {24'h0, exp_an});
    chk("model_ca", {24'h0, SSEG_CA}, {24'h0, exp_ca});
    if (rd_chk && !rst) chk("model_rdata", bus_rdata, exp_rd);
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus_sel = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    @(posedge clk); #1;
    bus_sel = 1'b0; bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    bus_sel = 1'b1; bus_we = 1'b0; bus_addr = a;
    @(posedge clk); #1;
    bus_sel = 1'b0;
    d = bus_rdata;
  endtask

  task automatic wait_start(input logic [7:0] v, input string name);
    int n = 0;
    while (SSEG_AN == v && n < 2000) begin @(negedge clk); n++; end
    while (SSEG_AN != v && n < 2000) begin @(negedge clk); n++; end
    chk(name, {24'h0, SSEG_AN}, {24'h0, v});
  endtask

  task automatic run_len(input logic [7:0] v, output int n);
    n = 1;
    @(negedge clk);
    while (SSEG_AN == v && n < 2000) begin n++; @(negedge clk); end
  endtask

  task automatic frame_scan(output int p, output logic [7:0] acc);
    p = 0; acc = '0;
    while (SSEG_AN == 8'hFE && p < 2000) begin @(negedge clk); p++; acc |= ~SSEG_AN; end
    while (SSEG_AN != 8'hFE && p < 2000) begin @(negedge clk); p++; acc |= ~SSEG_AN; end
  endtask

  logic [7:0] an_seq [8] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
  logic [7:0] ca_seq [8] = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h88, 8'h83, 8'hC6, 8'hA1};

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  acc;
    int          n, p;

    repeat (3) @(negedge clk);
    chk("reset_an", {24'h0, SSEG_AN}, 32'hFF);
    chk("reset_ca", {24'h0, SSEG_CA}, 32'hFF);
    chk("reset_rdata", bus_rdata, 32'h0);
    rst = 1'b0;
    bus_read(2'd3, rd); chk("reset_status", rd, 32'h0000_0007);
    bus_read(2'd1, rd); chk("reset_ctrl", rd, 32'h000F_FF00);

    // Full-brightness scan of 0x1234ABCD
    bus_write(2'd0, 32'h1234_ABCD);
    bus_write(2'd1, 32'h000F_FF01);
    for (int i = 0; i < 8; i++) begin
      wait_start(an_seq[i], "scan_an");
      chk("scan_ca", {24'h0, SSEG_CA}, {24'h0, ca_seq[i]});
      run_len(an_seq[i], n);
      chk("scan_on_len", n, 48);
    end

    // Mid-frame VALUE write is shadowed until the frame boundary
    wait_start(8'hEF, "tear_d4");
    bus_write(2'd0, 32'h0);
    wait_start(8'hFE, "tear_d0");
    chk("tear_old_ca", {24'h0, SSEG_CA}, 32'hA1);
    wait_start(8'h7F, "tear_d7");
    chk("tear_new_ca", {24'h0, SSEG_CA}, 32'hC0);
    bus_read(2'd3, rd); chk("tear_status", rd, 32'h0000_0207);

    // BRIGHT=0: 3 lit, 61 dark per slot
    bus_write(2'd1, 32'h0000_FF01);
    wait_start(8'hBF, "dim_d6");
    run_len(8'hBF, n); chk("dim_on_len", n, 3);
    run_len(8'hFF, n); chk("dim_off_len", n, 61);
    chk("dim_next", {24'h0, SSEG_AN}, 32'hDF);

    // DIGMASK=0x0F with DP on digit 0
    bus_write(2'd1, 32'h000F_0F01);
    bus_write(2'd2, 32'h0000_0001);
    wait_start(8'hFE, "mask_fe1");
    wait_start(8'hFE, "mask_fe2");
    chk("mask_dp_ca", {24'h0, SSEG_CA}, 32'h40);
    frame_scan(p, acc);
    chk("mask_period", p, 8 * P);
    chk("mask_lit", {24'h0, acc}, 32'h0F);

    // Disable mid-ON, then re-enable
    wait_start(8'hF7, "dis_d3");
    bus_write(2'd1, 32'h000F_0F00);
    @(negedge clk);
    chk("dis_still_lit", {24'h0, SSEG_AN}, 32'hF7);
    @(negedge clk);
    chk("dis_an", {24'h0, SSEG_AN}, 32'hFF);
    chk("dis_ca", {24'h0, SSEG_CA}, 32'hFF);
    bus_read(2'd3, rd); chk("dis_status", rd, 32'h0000_0503);
    bus_write(2'd1, 32'h000F_FF01);
    n = 0;
    do begin @(negedge clk); n++; end while (SSEG_AN == 8'hFF && n < 2000);
    chk("reen_delay", n, 19);
    chk("reen_an", {24'h0, SSEG_AN}, 32'h7F);

    // Leading-zero suppression (or its absence)
    bus_write(2'd2, 32'h0);
    bus_write(2'd0, 32'h0000_0250);
    wait_start(8'hFE, "lzs_fe");
    frame_scan(p, acc);
    chk("lzs_period", p, 8 * P);
    chk("lzs_ca0", {24'h0, SSEG_CA}, 32'hC0);
`ifdef SSEG_LZS_EN
    chk("lzs_lit_250", {24'h0, acc}, 32'h07);
`else
    chk("lzs_lit_250", {24'h0, acc}, 32'hFF);
`endif
    bus_write(2'd0, 32'h0);
    frame_scan(p, acc);
    chk("lzs_ca_zero", {24'h0, SSEG_CA}, 32'hC0);
`ifdef SSEG_LZS_EN
    chk("lzs_lit_zero", {24'h0, acc}, 32'h01);
`else
    chk("lzs_lit_zero", {24'h0, acc}, 32'hFF);
`endif

    // Asynchronous reset mid-operation
    wait_start(8'hFE, "arst_fe");
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("arst_an", {24'h0, SSEG_AN}, 32'hFF);
    chk("arst_ca", {24'h0, SSEG_CA}, 32'hFF);
    chk("arst_rdata", bus_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus_read(2'd1, rd); chk("arst_ctrl", rd, 32'h000F_FF00);
    bus_read(2'd0, rd); chk("arst_value", rd, 32'h0);
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
